// File: rtl/opnd_fetch_pkg.sv
// Shared constants, opcode encodings and the write-bypass match helper
// for the operand-fetch block.
package opnd_fetch_pkg;

  localparam int DATA_W = 32;
  localparam int REG_N  = 32;
  localparam int ADDR_W = 5;
  localparam int OP_W   = 3;

  typedef enum logic [OP_W-1:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SRL = 3'd4,
    ALU_SRA = 3'd5
  } alu_op_e;

  // True when a writeback in this cycle targets idx (register 0 never matches).
  function automatic logic wr_hit(input logic              we,
                                  input logic [ADDR_W-1:0] wa,
                                  input logic [ADDR_W-1:0] idx);
    return we && (wa != '0) && (wa == idx);
  endfunction

endpackage

// File: rtl/opnd_fetch_grf.sv
// General register file: 32 x 32 bits, register 0 hard-wired to zero,
// two combinational read ports with write-through bypass, one write port.
module grf
  import opnd_fetch_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0] ra0,
  input  logic [ADDR_W-1:0] ra1,
  output logic [DATA_W-1:0] rd0,
  output logic [DATA_W-1:0] rd1
);

  logic [DATA_W-1:0] r_mem [REG_N];

  // Storage write; reset clears every entry and wins over a concurrent write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REG_N; i++) r_mem[i] <= '0;
    end else if (we && (wa != '0)) begin
      r_mem[wa] <= wd;
    end
  end

  // Read ports: zero register first, then same-cycle writeback, then storage.
  always_comb begin
    rd0 = r_mem[ra0];
    rd1 = r_mem[ra1];
    if (ra0 == '0)                rd0 = '0;
    else if (wr_hit(we, wa, ra0)) rd0 = wd;
    if (ra1 == '0)                rd1 = '0;
    else if (wr_hit(we, wa, ra1)) rd1 = wd;
  end

endmodule

// File: rtl/opnd_fetch.sv
// Operand fetch: reads two source operands from the register file and
// registers them with the opcode for the ALU. While stalled, the held
// operands are refreshed by any writeback that targets their source index.
module opnd_fetch
  import opnd_fetch_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  input  logic [OP_W-1:0]   op_in,
  input  logic              stall,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  output logic              in_ready,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [OP_W-1:0]   ALUOp,
  output logic [ADDR_W-1:0] src_a,
  output logic [ADDR_W-1:0] src_b,
  output logic              out_valid
);

  logic [DATA_W-1:0] w_rd_a_p0;
  logic [DATA_W-1:0] w_rd_b_p0;

  logic [DATA_W-1:0] r_a_p1;
  logic [DATA_W-1:0] r_b_p1;
  logic [OP_W-1:0]   r_op_p1;
  logic [ADDR_W-1:0] r_src_a_p1;
  logic [ADDR_W-1:0] r_src_b_p1;
  logic              r_vld_p1;

  grf u_grf (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .wa    (wa),
    .wd    (wd),
    .ra0   (rs),
    .ra1   (rt),
    .rd0   (w_rd_a_p0),
    .rd1   (w_rd_b_p0)
  );

  // Upstream handshake: a new instruction is accepted whenever the output stage advances.
  assign in_ready = ~stall;

  // Stage p0 -> p1: capture on advance; on stall, keep the instruction but track writebacks.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a_p1     <= '0;
      r_b_p1     <= '0;
      r_op_p1    <= '0;
      r_src_a_p1 <= '0;
      r_src_b_p1 <= '0;
      r_vld_p1   <= 1'b0;
    end else if (!stall) begin
      r_a_p1     <= w_rd_a_p0;
      r_b_p1     <= w_rd_b_p0;
      r_op_p1    <= op_in;
      r_src_a_p1 <= rs;
      r_src_b_p1 <= rt;
      r_vld_p1   <= in_valid;
    end else if (r_vld_p1) begin
      if (wr_hit(we, wa, r_src_a_p1)) r_a_p1 <= wd;
      if (wr_hit(we, wa, r_src_b_p1)) r_b_p1 <= wd;
    end
  end

  assign A         = r_a_p1;
  assign B         = r_b_p1;
  assign ALUOp     = r_op_p1;
  assign src_a     = r_src_a_p1;
  assign src_b     = r_src_b_p1;
  assign out_valid = r_vld_p1;

endmodule
